// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and segment constants for the BCD seven-segment scanner
package bcd_pkg;
  typedef logic [6:0] seg7_t;
  typedef enum logic [2:0] {S_OFF, S_ONES, S_GAP1, S_TENS, S_GAP0} scan_state_t;
  typedef struct packed {
    logic       carry;
    logic [3:0] bcd;
  } bcd2_t;
  localparam seg7_t SEG_0    = 7'h3F;
  localparam seg7_t SEG_1    = 7'h06;
  localparam seg7_t SEG_2    = 7'h5B;
  localparam seg7_t SEG_3    = 7'h4F;
  localparam seg7_t SEG_4    = 7'h66;
  localparam seg7_t SEG_5    = 7'h6D;
  localparam seg7_t SEG_6    = 7'h7D;
  localparam seg7_t SEG_7    = 7'h07;
  localparam seg7_t SEG_8    = 7'h7F;
  localparam seg7_t SEG_9    = 7'h6F;
  localparam seg7_t SEG_DASH = 7'h40;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high {g..a} segments; anything above 9 shows a dash
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output seg7_t      seg_o
);
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 2-digit multiplexed seven-segment scanner with frame-aligned value commit.
// Optional LEADING_ZERO_BLANK_EN keeps the tens digit dark when the tens carry is 0.
module bcd_seg_scan
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] bcd,
  input  logic       carry,
  output logic [6:0] seg,
  output logic [1:0] digit_en
);
  localparam int MAXC = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXC > 2 ? MAXC : 2);
  localparam logic [CW-1:0] RD_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0 ? GAP_CYCLES : 1) - 1);
  localparam bit HAS_GAP = GAP_CYCLES > 0;
  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bcd2_t         shadow_q, shadow_d, disp_q, disp_d;
  logic          pend_q, pend_d;
  seg7_t         seg_q, seg_d, seg_ones, seg_tens;
  logic [1:0]    en_q, en_d;
  logic          xfer, commit, tens_on;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   state_d = pend_q ? S_ONES : S_OFF;
      S_ONES:  if (cnt_q == RD_LAST) state_d = HAS_GAP ? S_GAP1 : S_TENS;
      S_GAP1:  if (cnt_q == GAP_LAST) state_d = S_TENS;
      S_TENS:  if (cnt_q == RD_LAST) state_d = HAS_GAP ? S_GAP0 : S_ONES;
      S_GAP0:  if (cnt_q == GAP_LAST) state_d = S_ONES;
      default: state_d = S_OFF;
    endcase
  end
  assign xfer     = load_valid && !pend_q;
  assign commit   = state_d == S_ONES && state_q != S_ONES;
  assign shadow_d = xfer ? bcd2_t'({carry, bcd}) : shadow_q;
  // A transfer landing on the commit edge wins and waits for the next frame
  assign pend_d   = xfer || (pend_q && !commit);
  assign disp_d   = commit ? shadow_q : disp_q;
  assign cnt_d    = (state_d != state_q || state_q == S_OFF) ? '0 : cnt_q + 1'b1;
  seg7_decode u_ones (.digit_i(disp_d.bcd),              .seg_o(seg_ones));
  seg7_decode u_tens (.digit_i({3'b000, disp_d.carry}),  .seg_o(seg_tens));
`ifdef LEADING_ZERO_BLANK_EN
  assign tens_on = state_d == S_TENS && disp_d.carry;
`else
  assign tens_on = state_d == S_TENS;
`endif
  assign en_d  = {tens_on, state_d == S_ONES};
  assign seg_d = en_d[0] ? seg_ones : en_d[1] ? seg_tens : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      seg_q    <= '0;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
    end
  end
  assign load_ready = !pend_q;
  assign seg        = seg_q;
  assign digit_en   = en_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: randomized bench for bcd_seg_scan with a frame-position reference model;
// runs a gapped (GAP_CYCLES=1) and a gapless (GAP_CYCLES=0) instance side by side.
module tb_bcd_seg_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       carry = 1'b0;
  logic       rdy0, rdy1;
  logic [6:0] seg0, seg1;
  logic [1:0] en0, en1;
  logic [9:0] got [2];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  bcd_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy0),
    .bcd(bcd), .carry(carry), .seg(seg0), .digit_en(en0));
  bcd_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy1),
    .bcd(bcd), .carry(carry), .seg(seg1), .digit_en(en1));
  assign got[0] = {rdy0, en0, seg0};
  assign got[1] = {rdy1, en1, seg1};
  // Model: t is the cycle position inside a frame that starts at the ones slot
  typedef struct {
    bit         st;
    int         t;
    bit         pend;
    logic [4:0] sh;
    logic [4:0] disp;
  } mdl_t;
  mdl_t m [2];
  logic [6:0] tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  function automatic mdl_t mrst();
    mdl_t r;
    r.st = 0; r.t = 0; r.pend = 0; r.sh = '0; r.disp = '0;
    return r;
  endfunction
  function automatic mdl_t step(mdl_t s, int f, bit v, logic [4:0] d);
    mdl_t n = s;
    if (!s.st) begin
      if (s.pend) begin n.st = 1; n.t = 0; n.disp = s.sh; n.pend = 0; end
    end else begin
      n.t = (s.t + 1) % f;
      if (n.t == 0) begin n.disp = s.sh; n.pend = 0; end
    end
    if (v && !s.pend) begin n.sh = d; n.pend = 1; end
    return n;
  endfunction
  function automatic logic [6:0] dec(logic [3:0] d);
    return d > 4'd9 ? 7'h40 : tbl[d];
  endfunction
  function automatic logic [9:0] expv(mdl_t s, int g);
    logic [1:0] e = 2'b00;
    logic [6:0] sg = 7'h00;
    if (s.st && s.t < 4) begin
      e = 2'b01; sg = dec(s.disp[3:0]);
    end else if (s.st && s.t >= 4 + g && s.t < 8 + g) begin
      e = 2'b10; sg = dec({3'b000, s.disp[4]});
`ifdef LEADING_ZERO_BLANK_EN
      if (!s.disp[4]) begin e = 2'b00; sg = 7'h00; end
`endif
    end
    return {!s.pend, e, sg};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mrst();
      m[1] <= mrst();
    end else begin
      m[0] <= step(m[0], 10, load_valid, {carry, bcd});
      m[1] <= step(m[1], 8, load_valid, {carry, bcd});
    end
  end
  task automatic test_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== 10'h200) $display("FAIL reset_hold dut%0d got=%h exp=%h", k, got[k], 10'h200);
      else passed++;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== 10'h200 || got[k] !== expv(m[k], 1 - k))
          $display("FAIL reset_idle dut%0d cyc%0d got=%h exp=%h", k, c, got[k], 10'h200);
        else passed++;
      end
    end
  endtask
  task automatic test_load_15();
    @(posedge clk); #1;
    load_valid = 1'b1; carry = 1'b1; bcd = 4'd5;
    @(posedge clk); #1;
    load_valid = 1'b0;
    total++;
    if (got[0] !== 10'h000) $display("FAIL load15_pending got=%h exp=%h", got[0], 10'h000);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (got[0] !== 10'h2ED) $display("FAIL load15_first_ones got=%h exp=%h", got[0], 10'h2ED);
    else passed++;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== expv(m[k], 1 - k)) $display("FAIL load15 dut%0d cyc%0d got=%h exp=%h", k, c, got[k], expv(m[k], 1 - k));
        else passed++;
      end
    end
  endtask
  task automatic test_midframe_load();
    int n = 0;
    while (!(m[0].st && m[0].t == 5) && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 20) $display("FAIL midframe_wait got=timeout exp=tens_slot");
    else passed++;
    load_valid = 1'b1; carry = 1'b0; bcd = 4'd7;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      load_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== expv(m[k], 1 - k)) $display("FAIL midframe dut%0d cyc%0d got=%h exp=%h", k, c, got[k], expv(m[k], 1 - k));
        else passed++;
      end
    end
  endtask
  task automatic test_hold_valid();
    load_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      bcd = 4'($urandom_range(0, 9)); carry = 1'($urandom);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== expv(m[k], 1 - k)) $display("FAIL hold_valid dut%0d cyc%0d got=%h exp=%h", k, c, got[k], expv(m[k], 1 - k));
        else passed++;
      end
    end
    load_valid = 1'b0;
  endtask
  task automatic test_invalid();
    load_valid = 1'b1; carry = 1'b0; bcd = 4'hC;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 12) load_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== expv(m[k], 1 - k)) $display("FAIL invalid dut%0d cyc%0d got=%h exp=%h", k, c, got[k], expv(m[k], 1 - k));
        else passed++;
      end
    end
    total++;
    if (m[0].disp !== 5'h0C) $display("FAIL invalid_committed got=%h exp=%h", m[0].disp, 5'h0C);
    else passed++;
  endtask
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      bcd = 4'($urandom); carry = 1'($urandom);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== expv(m[k], 1 - k)) $display("FAIL random dut%0d cyc%0d got=%h exp=%h", k, c, got[k], expv(m[k], 1 - k));
        else passed++;
      end
`ifndef LEADING_ZERO_BLANK_EN
      total++;
      if (m[1].st && en1 === 2'b00) $display("FAIL nogap_dark cyc%0d got=%b exp=nonzero", c, en1);
      else passed++;
`endif
    end
    load_valid = 1'b0;
  endtask
  task automatic test_async_reset();
    int n = 0;
    load_valid = 1'b1; carry = 1'b1; bcd = 4'd9;
    while (!(m[0].st && m[0].t == 1 && m[0].pend) && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 40) $display("FAIL async_wait got=timeout exp=ones_slot");
    else passed++;
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== 10'h200) $display("FAIL async_reset dut%0d got=%h exp=%h", k, got[k], 10'h200);
      else passed++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== 10'h200) $display("FAIL post_reset dut%0d cyc%0d got=%h exp=%h", k, c, got[k], 10'h200);
        else passed++;
      end
    end
  endtask
  initial begin
    test_reset();
    test_load_15();
    test_midframe_load();
    test_hold_valid();
    test_invalid();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the binary-to-BCD converter. It takes one BCD ones digit plus the tens carry (displayed values 0..15) and drives a 2-digit multiplexed seven-segment display.
- Holds the displayed value in a shadow register and scans the digits with a refresh counter, inserting anti-ghosting blank gaps between digits.
- New values are accepted through a valid/ready handshake. They are committed only at a frame boundary, so a frame never shows half of one value and half of another.

Parameters:
- REFRESH_DIV, 1000, clock cycles each digit is lit per slot (must be >= 1).
- GAP_CYCLES, 2, blank cycles between digit slots (0 means no gap states).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  upstream presents {carry,bcd}
- load_ready  out  1  block can accept a new value
- bcd  in  4  ones digit 0..9 (values >9 are treated as invalid)
- carry  in  1  tens digit (0 or 1)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- digit_en  out  2  one-hot digit enable; [0]=ones, [1]=tens; active-high

Behaviour:
- One clock domain; reset is asynchronous and active-low. The clock and reset ports are named clk and rst_n.
- Reset values: seg=0, digit_en=0, load_ready=1, state S_OFF, slot counter=0, shadow=0, displayed=0, pending=0.
- Handshake:
  - A transfer occurs on a rising edge where load_valid&&load_ready.
  - On transfer, {carry,bcd} is captured into shadow, pending is set, and load_ready goes low the next cycle.
  - While pending=1, load_ready=0 and load_valid is ignored.
- Commit: displayed<=shadow and pending<=0 on entry to S_ONES. load_ready returns high the cycle after the commit.
- FSM states: S_OFF, S_ONES, S_GAP1, S_TENS, S_GAP0.
  - S_OFF -> S_ONES on the cycle after the first transfer.
  - S_ONES -> S_GAP1 after REFRESH_DIV cycles.
  - S_GAP1 -> S_TENS after GAP_CYCLES cycles.
  - S_TENS -> S_GAP0 after REFRESH_DIV cycles.
  - S_GAP0 -> S_ONES after GAP_CYCLES cycles.
  - When GAP_CYCLES=0, the gap states are skipped: S_ONES goes directly to S_TENS, and S_TENS goes directly to S_ONES.
- Frame length is 2*REFRESH_DIV+2*GAP_CYCLES. The block never returns to S_OFF except by reset.
- Slot counter:
  - Width is $clog2(max(REFRESH_DIV,GAP_CYCLES,2)).
  - It clears on every state change and counts 0..limit-1.
- Outputs are registered and change on the same edge as the state:
  - S_OFF and gap states: digit_en=00, seg=0.
  - S_ONES: digit_en=01, seg=decode(displayed.bcd).
  - S_TENS: digit_en=10, seg=decode({3'b0,displayed.carry}).
- Decode table (hex, {g..a}): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Any value >9 decodes to 40 (dash, segment g only).
- Reset mid-frame: outputs blank immediately (asynchronous), and the pending value is lost.
- A transfer during S_OFF commits at the S_OFF->S_ONES transition, one cycle later.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: in S_TENS with displayed.carry=0, seg=0 and digit_en=00. The tens position stays dark and the slot timing is unchanged.
- When undefined: the tens digit always shows 0 or 1.

Decomposition:
- Shared package bcd_pkg holds:
  - typedef seg7_t (logic[6:0]);
  - the enum scan_state_t;
  - localparam seg7 constants SEG_0..SEG_9 and SEG_DASH;
  - a struct bcd2_t {carry, bcd}.
- Sub-module seg7_decode: combinational, 4-bit digit in, seg7_t out, two instances (ones and tens).

Test Plan:
- Use REFRESH_DIV=4, GAP_CYCLES=1 throughout.
- Reset release with no load -> seg=00 and digit_en=00 for 20 cycles; load_ready=1.
- Load {carry=1,bcd=5} -> next cycle S_ONES: digit_en=01 and seg=6D for 4 cycles, then 1 blank cycle, then digit_en=10 and seg=06 for 4 cycles, then 1 blank cycle; the frame repeats with period 10.
- Load {0,7} while displaying {1,5}, mid-S_TENS -> load_ready=0 until the next S_ONES entry; the current frame finishes showing 15; the next frame shows seg=07 on ones, and on tens either 3F, or dark if LEADING_ZERO_BLANK_EN is defined.
- Hold load_valid=1 with changing data while pending -> only the first value is captured; load_ready reasserts exactly one cycle after commit.
- Load bcd=4'hC (invalid) -> the ones slot shows seg=40.
- Assert rst_n=0 mid S_ONES -> seg, digit_en and state clear without waiting for a clock edge; load_ready=1; no display until the next load.
- GAP_CYCLES=0 build: digit_en alternates 01/10 every 4 cycles and is never 00 after the first load.
